// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store sequencer: funct3 encodings,
// completion codes, FSM state encoding and access classification.
package lsu_ctrl_pkg;

    // Load/store width encodings carried in funct3
    localparam logic [2:0] LS_B_OP  = 3'b000;
    localparam logic [2:0] LS_H_OP  = 3'b001;
    localparam logic [2:0] LS_W_OP  = 3'b010;
    localparam logic [2:0] LS_BU_OP = 3'b100;
    localparam logic [2:0] LS_HU_OP = 3'b101;

    // Completion code reported alongside o_done
    typedef enum logic [1:0] {
        LSU_ERR_OK       = 2'b00,
        LSU_ERR_MISALIGN = 2'b01,
        LSU_ERR_ILLEGAL  = 2'b10,
        LSU_ERR_TIMEOUT  = 2'b11
    } lsu_err_e;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUS  = 2'b01,
        ST_DONE = 2'b10
    } lsu_state_e;

    // Decide at accept time whether an access can go to the bus.
    // Alignment is checked first, so a misaligned halfword store with the
    // unsigned encoding still reports misaligned.
    function automatic lsu_err_e classify(input logic we, input logic [2:0] f3,
                                          input logic [1:0] addr_lo);
        lsu_err_e res;
        res = LSU_ERR_OK;
        case (f3)
            LS_H_OP, LS_HU_OP: if (addr_lo[0])       res = LSU_ERR_MISALIGN;
            LS_W_OP:           if (addr_lo != 2'b00) res = LSU_ERR_MISALIGN;
            default:           ;
        endcase
        if (res == LSU_ERR_OK) begin
            // 011/11x are undefined; stores have no unsigned variants
            if ((f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]))
                res = LSU_ERR_ILLEGAL;
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering between a right-justified core value and the 32-bit
// memory word: byte enables, lane-replicated store data, and load
// extraction with sign/zero extension.
module lsu_align
    import lsu_ctrl_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    // Select the addressed lane, then build enables, store data and load data
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata;

        case (addr_lo)
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (funct3)
            LS_B_OP, LS_BU_OP: begin
                be         = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                // Sign comes from the selected byte, not from word bit 31
                rdata_ext  = funct3[2] ? {24'b0, rbyte} : {{24{rbyte[7]}}, rbyte};
            end
            LS_H_OP, LS_HU_OP: begin
                be         = 4'b0011 << addr_lo;
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = funct3[2] ? {16'b0, rhalf} : {{16{rhalf[15]}}, rhalf};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: accepts one access from execute, runs a single
// bus transaction (or faults it immediately), and reports completion with
// a one-cycle done pulse. Lane steering lives in lsu_align.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_req,
    input  logic            i_we,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_busy,
    output logic            o_done,
    output logic [1:0]      o_err,
    output logic [XLEN-1:0] o_rdata,
    output logic            o_bus_req,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [3:0]      o_bus_be,
    output logic [XLEN-1:0] o_bus_wdata,
    input  logic            i_bus_ack,
    input  logic [XLEN-1:0] i_bus_rdata
);

    localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    lsu_state_e      state_q, state_d;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [CW-1:0]   tmo_cnt_q;
    lsu_err_e        err_q;
    logic [XLEN-1:0] rdata_q;

    logic            accept;
    lsu_err_e        acc_err;
    logic            timeout_hit;
    logic [3:0]      be;
    logic [31:0]     wdata_lane;
    logic [31:0]     rdata_ext;

    assign accept  = (state_q == ST_IDLE) && i_req;
    assign acc_err = classify(i_we, i_funct3, i_addr[1:0]);

    // Last allowed bus cycle without ack; a zero limit disables the check
    assign timeout_hit = (TIMEOUT_CYC != 0) && (tmo_cnt_q == CW'(TIMEOUT_CYC - 1));

    lsu_align u_align (
        .funct3     (f3_q),
        .addr_lo    (addr_q[1:0]),
        .wdata      (wdata_q),
        .rdata      (i_bus_rdata),
        .be         (be),
        .wdata_lane (wdata_lane),
        .rdata_ext  (rdata_ext)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!i_rstn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Next-state and output decode; bus outputs are forced to zero outside BUS
    always_comb begin
        state_d     = state_q;
        o_busy      = (state_q != ST_IDLE);
        o_done      = 1'b0;
        o_bus_req   = 1'b0;
        o_bus_we    = 1'b0;
        o_bus_addr  = '0;
        o_bus_be    = 4'b0000;
        o_bus_wdata = '0;

        case (state_q)
            ST_IDLE: begin
                if (i_req) state_d = (acc_err == LSU_ERR_OK) ? ST_BUS : ST_DONE;
            end
            ST_BUS: begin
                o_bus_req   = 1'b1;
                o_bus_we    = we_q;
                o_bus_addr  = {addr_q[XLEN-1:2], 2'b00};
                o_bus_be    = be;
                o_bus_wdata = wdata_lane;
                if (i_bus_ack || timeout_hit) state_d = ST_DONE;
            end
            ST_DONE: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request at accept and count bus cycles waiting for ack
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            we_q      <= 1'b0;
            f3_q      <= 3'b000;
            addr_q    <= '0;
            wdata_q   <= '0;
            tmo_cnt_q <= '0;
        end else if (accept) begin
            we_q      <= i_we;
            f3_q      <= i_funct3;
            addr_q    <= i_addr;
            wdata_q   <= i_wdata;
            tmo_cnt_q <= '0;
        end else if (state_q == ST_BUS) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    // Completion status and load result, updated on the edge that enters DONE
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            err_q   <= LSU_ERR_OK;
            rdata_q <= '0;
        end else if (accept && (acc_err != LSU_ERR_OK)) begin
            err_q   <= acc_err;
            rdata_q <= '0;
        end else if ((state_q == ST_BUS) && i_bus_ack) begin
            // Ack wins over a timeout reached in the same cycle
            err_q   <= LSU_ERR_OK;
            rdata_q <= we_q ? '0 : rdata_ext;
        end else if ((state_q == ST_BUS) && timeout_hit) begin
            err_q   <= LSU_ERR_TIMEOUT;
            rdata_q <= '0;
        end
    end

    assign o_err   = err_q;
    assign o_rdata = rdata_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a table of single accesses with
// hand-computed results, followed by sequences for busy/ack-outside-BUS,
// back-to-back acceptance and reset in the middle of a bus transaction.
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic        busy, done;
    logic [1:0]  err;
    logic [31:0] rdata;
    logic        bus_req, bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.XLEN(32), .TIMEOUT_CYC(4)) dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_req       (req),
        .i_we        (we),
        .i_funct3    (f3),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_err       (err),
        .o_rdata     (rdata),
        .o_bus_req   (bus_req),
        .o_bus_we    (bus_we),
        .o_bus_addr  (bus_addr),
        .o_bus_be    (bus_be),
        .o_bus_wdata (bus_wdata),
        .i_bus_ack   (bus_ack),
        .i_bus_rdata (bus_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;     // word returned with ack
        int          ack_at;    // BUS cycle index carrying ack (99 = never)
        logic [1:0]  exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_be;
        logic [31:0] exp_bwdata;
        int          exp_bus;   // cycles with o_bus_req high
        int          exp_done;  // cycle of o_done, request cycle = 1
    } vec_t;

    localparam int NV = 17;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one access in the first free cycle and follow it to o_done
    task automatic run_access(input vec_t v, input string tag);
        int  cyc;
        int  nbus;
        bit  fin;
        @(posedge clk); #1;
        req = 1'b1; we = v.we; f3 = v.f3; addr = v.addr; wdata = v.wdata; bus_ack = 1'b0;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
        cyc = 2; nbus = 0; fin = 1'b0;
        for (int k = 0; k < 20 && !fin; k++) begin
            @(negedge clk);
            if (done) begin
                fin = 1'b1;
                check({tag, "_done_cycle"}, cyc, v.exp_done);
                check({tag, "_bus_cycles"}, nbus, v.exp_bus);
                check({tag, "_err"}, {30'b0, err}, {30'b0, v.exp_err});
                check({tag, "_rdata"}, rdata, v.exp_rdata);
                check({tag, "_bus_req_in_done"}, {31'b0, bus_req}, 32'd0);
            end else begin
                if (bus_req) begin
                    check({tag, "_bus_addr"}, bus_addr, {v.addr[31:2], 2'b00});
                    check({tag, "_bus_we"}, {31'b0, bus_we}, {31'b0, v.we});
                    check({tag, "_bus_be"}, {28'b0, bus_be}, {28'b0, v.exp_be});
                    check({tag, "_bus_wdata"}, bus_wdata, v.exp_bwdata);
                    if (nbus == v.ack_at) begin
                        bus_ack = 1'b1; bus_rdata = v.rdata;
                    end
                    nbus++;
                end
                @(posedge clk); #1;
                bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;
                cyc++;
            end
        end
        if (!fin) check({tag, "_done_seen"}, 32'd0, 32'd1);
    endtask

    initial begin
        //        we  f3      addr          wdata         rdata         ack err    exp_rdata     be       bwdata        bus done
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 2'b00, 32'hDEAD_BEEF, 4'b1111, 32'h0,        1, 3};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_0011, 0, 2'b00, 32'hFFFF_FF80, 4'b1000, 32'h0,        1, 3};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_0011, 1, 2'b00, 32'h0000_0080, 4'b1000, 32'h0,        2, 4};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_0011, 0, 2'b00, 32'hFFFF_80FF, 4'b1100, 32'h0,        1, 3};
        vecs[4]  = '{1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h7F00_0080, 0, 2'b00, 32'hFFFF_FF80, 4'b0001, 32'h0,        1, 3};
        vecs[5]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h80FF_8011, 0, 2'b00, 32'h0000_8011, 4'b0011, 32'h0,        1, 3};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h1111_1111, 0, 2'b01, 32'h0,        4'b0000, 32'h0,        0, 2};
        vecs[7]  = '{1'b1, 3'b000, 32'h0000_0201, 32'h0000_00A5, 32'h1234_5678, 1, 2'b00, 32'h0,        4'b0010, 32'hA5A5_A5A5, 2, 4};
        vecs[8]  = '{1'b1, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 32'h1234_5678, 0, 2'b00, 32'h0,        4'b1100, 32'hBEEF_BEEF, 1, 3};
        vecs[9]  = '{1'b1, 3'b010, 32'h0000_0404, 32'hCAFE_F00D, 32'h1234_5678, 2, 2'b00, 32'h0,        4'b1111, 32'hCAFE_F00D, 3, 5};
        vecs[10] = '{1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h1122_3344, 0, 2'b00, 32'h1122_3344, 4'b1111, 32'h0,        1, 3};
        vecs[11] = '{1'b1, 3'b101, 32'h0000_0100, 32'h0000_FFFF, 32'h0,        0, 2'b10, 32'h0,        4'b0000, 32'h0,        0, 2};
        vecs[12] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 2'b01, 32'h0,        4'b0000, 32'h0,        0, 2};
        vecs[13] = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 2'b10, 32'h0,        4'b0000, 32'h0,        0, 2};
        vecs[14] = '{1'b0, 3'b010, 32'h0000_0600, 32'h0,        32'h0,        99, 2'b11, 32'h0,       4'b1111, 32'h0,        4, 6};
        vecs[15] = '{1'b0, 3'b010, 32'h0000_0604, 32'h0,        32'h0BAD_F00D, 3, 2'b00, 32'h0BAD_F00D, 4'b1111, 32'h0,     4, 6};
        vecs[16] = '{1'b1, 3'b100, 32'h0000_0100, 32'h0000_0077, 32'h0,        0, 2'b10, 32'h0,        4'b0000, 32'h0,        0, 2};

        rstn = 1'b0; req = 1'b0; we = 1'b0; f3 = 3'b000; addr = '0; wdata = '0;
        bus_ack = 1'b0; bus_rdata = 32'h5A5A_5A5A;

        // Reset state
        #3;
        check("rst_busy",      {31'b0, busy},    32'd0);
        check("rst_done",      {31'b0, done},    32'd0);
        check("rst_err",       {30'b0, err},     32'd0);
        check("rst_rdata",     rdata,            32'd0);
        check("rst_bus_req",   {31'b0, bus_req}, 32'd0);
        check("rst_bus_we",    {31'b0, bus_we},  32'd0);
        check("rst_bus_addr",  bus_addr,         32'd0);
        check("rst_bus_be",    {28'b0, bus_be},  32'd0);
        check("rst_bus_wdata", bus_wdata,        32'd0);
        @(negedge clk); rstn = 1'b1;

        // Table: issued back-to-back, each in the IDLE cycle after the previous DONE
        for (int i = 0; i < NV; i++) run_access(vecs[i], $sformatf("v%0d", i));

        // Done is a single-cycle pulse, result is held, stray ack in IDLE is ignored
        run_access(vecs[0], "pulse");
        @(negedge clk);
        check("pulse_done_low",  {31'b0, done}, 32'd0);
        check("pulse_busy_low",  {31'b0, busy}, 32'd0);
        check("pulse_rdata_hold", rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1; bus_ack = 1'b1; bus_rdata = 32'h0;
        @(negedge clk);
        check("idle_ack_busy", {31'b0, busy}, 32'd0);
        check("idle_ack_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1; bus_ack = 1'b0;
        @(negedge clk);
        check("idle_ack_after_done", {31'b0, done}, 32'd0);
        check("idle_ack_rdata", rdata, 32'hDEAD_BEEF);

        // Request held high across the whole access: re-accepted only after DONE
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0000_0700;
        @(posedge clk); #1;                      // cycle 2: BUS
        @(negedge clk);
        check("hold_bus_req_c2", {31'b0, bus_req}, 32'd1);
        bus_ack = 1'b1; bus_rdata = 32'h0102_0304;
        @(posedge clk); #1; bus_ack = 1'b0;      // cycle 3: DONE
        @(negedge clk);
        check("hold_done_c3", {31'b0, done}, 32'd1);
        check("hold_rdata_c3", rdata, 32'h0102_0304);
        @(posedge clk); #1;                      // cycle 4: IDLE, req sampled
        @(negedge clk);
        check("hold_busy_c4", {31'b0, busy}, 32'd0);
        check("hold_done_c4", {31'b0, done}, 32'd0);
        @(posedge clk); #1; req = 1'b0;          // cycle 5: BUS again
        @(negedge clk);
        check("hold_bus_req_c5", {31'b0, bus_req}, 32'd1);
        check("hold_bus_addr_c5", bus_addr, 32'h0000_0700);
        bus_ack = 1'b1; bus_rdata = 32'hA0B0_C0D0;
        @(posedge clk); #1; bus_ack = 1'b0;
        @(negedge clk);
        check("hold_done_c6", {31'b0, done}, 32'd1);
        check("hold_rdata_c6", rdata, 32'hA0B0_C0D0);

        // Reset in the middle of a bus transaction
        @(posedge clk); #1;
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h0000_0900;
        @(posedge clk); #1; req = 1'b0;
        @(negedge clk);
        check("mid_rst_bus_req_before", {31'b0, bus_req}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        check("mid_rst_bus_req", {31'b0, bus_req}, 32'd0);
        check("mid_rst_busy",    {31'b0, busy},    32'd0);
        check("mid_rst_bus_addr", bus_addr,        32'd0);
        check("mid_rst_rdata",    rdata,           32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("mid_rst_no_done_%0d", k), {31'b0, done}, 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_done", {31'b0, done}, 32'd0);
        run_access(vecs[0], "post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    // Hard stop in case a sequence stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
